// File: rtl/pipe_adder_pkg.sv
// Shared types for the pipelined chunked adder: operation encoding and the
// per-stage control beat (valid bit plus the carry handed to the next stage).
package pipe_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/pipe_adder_chunk.sv
// CHUNK-wide combinational adder slice with carry in and carry out; one
// instance per pipeline stage of pipe_adder.
module pipe_adder_chunk
    import pipe_adder_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co
);

    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor, CHUNK bits per stage, with valid/ready
// flow control. Optional macro PIPE_ADDER_SAT_EN saturates addC on signed overflow.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] addC,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTAGE = WIDTH / CHUNK;
    localparam int LAST   = NSTAGE - 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("pipe_adder: WIDTH must be a multiple of CHUNK");
    end

    logic             advance;
    logic             is_sub;

    stage_ctl_t       ctl_r  [NSTAGE];
    logic [WIDTH-1:0] a_r    [NSTAGE];
    logic [WIDTH-1:0] b_r    [NSTAGE];
    logic [WIDTH-1:0] s_r    [NSTAGE];
    logic             ovf_r;

    stage_ctl_t       ctl_in [NSTAGE];
    logic [WIDTH-1:0] a_in   [NSTAGE];
    logic [WIDTH-1:0] b_in   [NSTAGE];
    logic [WIDTH-1:0] s_in   [NSTAGE];
    logic [WIDTH-1:0] s_next [NSTAGE];
    logic [CHUNK-1:0] chunk_sum [NSTAGE];
    logic             chunk_co  [NSTAGE];

    logic             a_sign;
    logic             b_sign;
    logic             r_sign;
    logic             ovf_next;
    logic [WIDTH-1:0] res_next;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign is_sub    = (op_e'(op) == OP_SUB);

    // Subtraction enters stage 0 as A + ~B + 1; later stages take the skewed operands.
    always_comb begin
        a_in[0]         = inputA;
        b_in[0]         = is_sub ? ~inputB : inputB;
        ctl_in[0].valid = in_valid;
        ctl_in[0].carry = is_sub ? 1'b1 : cin;
        s_in[0]         = '0;
        for (int k = 1; k < NSTAGE; k++) begin
            a_in[k]   = a_r[k-1];
            b_in[k]   = b_r[k-1];
            ctl_in[k] = ctl_r[k-1];
            s_in[k]   = s_r[k-1];
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        pipe_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a   (a_in[k][k*CHUNK +: CHUNK]),
            .b   (b_in[k][k*CHUNK +: CHUNK]),
            .ci  (ctl_in[k].carry),
            .sum (chunk_sum[k]),
            .co  (chunk_co[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            s_next[k] = s_in[k];
            s_next[k][k*CHUNK +: CHUNK] = chunk_sum[k];
        end
    end

    assign a_sign   = a_in[LAST][WIDTH-1];
    assign b_sign   = b_in[LAST][WIDTH-1];
    assign r_sign   = s_next[LAST][WIDTH-1];
    assign ovf_next = (a_sign == b_sign) && (r_sign != a_sign);

`ifdef PIPE_ADDER_SAT_EN
    // Clamp toward the operand sign: 0x7F..F for positive, 0x80..0 for negative.
    assign res_next = ovf_next ? {a_sign, {(WIDTH-1){~a_sign}}} : s_next[LAST];
`else
    assign res_next = s_next[LAST];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                ctl_r[k] <= '0;
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                s_r[k]   <= '0;
            end
            ovf_r <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < NSTAGE; k++) begin
                ctl_r[k].valid <= ctl_in[k].valid;
                ctl_r[k].carry <= chunk_co[k];
                a_r[k]         <= a_in[k];
                b_r[k]         <= b_in[k];
                s_r[k]         <= (k == LAST) ? res_next : s_next[k];
            end
            ovf_r <= ovf_next;
        end
    end

    assign out_valid = ctl_r[LAST].valid;
    assign addC      = s_r[LAST];
    assign cout      = ctl_r[LAST].carry;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=32, CHUNK=8): arithmetic model with
// an in-order scoreboard, plus literal expectations. Honours PIPE_ADDER_SAT_EN.
module tb_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inputA;
    logic [31:0] inputB;
    logic        cin;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] addC;
    logic        cout;
    logic        ovf;

    pipe_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inputA    (inputA),
        .inputB    (inputB),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .addC      (addC),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t        expq[$];
    int          acc_log[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          cycle        = 0;
    int          results_seen = 0;
    logic [31:0] last_sum;
    logic        last_cout;
    logic        last_ovf;
    int          last_latency;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result straight from the arithmetic definition.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic o);
        exp_t        r;
        logic [31:0] bx;
        logic [32:0] full;
        bx     = o ? ~b : b;
        full   = {1'b0, a} + {1'b0, bx} + {32'd0, (o ? 1'b1 : c)};
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (a[31] == bx[31]) && (full[31] != a[31]);
`ifdef PIPE_ADDER_SAT_EN
        if (r.ovf) r.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        r.acc  = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            expq.delete();
        end else begin
            checkValue("in_ready rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checkValue("spurious out_valid", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    checkValue("addC", {32'd0, addC}, {32'd0, e.sum});
                    checkValue("cout", {63'd0, cout}, {63'd0, e.cout});
                    checkValue("ovf", {63'd0, ovf}, {63'd0, e.ovf});
                    last_sum     = addC;
                    last_cout    = cout;
                    last_ovf     = ovf;
                    last_latency = cycle - e.acc;
                end
                results_seen++;
            end
            if (in_valid && in_ready) begin
                e     = model(inputA, inputB, cin, op);
                e.acc = cycle;
                expq.push_back(e);
                acc_log.push_back(cycle);
            end
        end
    end

    // Drive one beat from posedge+1 and hold it until the DUT accepts it.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic o);
        int waits = 0;
        inputA   = a;
        inputB   = b;
        cin      = c;
        op       = o;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) checkValue("accept timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the next result and pin it against hand-computed literals.
    task automatic checkOutput(input string name, input int base, input logic [31:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf);
        int waits = 0;
        while (results_seen == base && waits < 30) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (results_seen == base) begin
            checkValue({name, " result timeout"}, 64'd1, 64'd0);
        end else begin
            checkValue({name, " addC"}, {32'd0, last_sum}, {32'd0, exp_sum});
            checkValue({name, " cout"}, {63'd0, last_cout}, {63'd0, exp_cout});
            checkValue({name, " ovf"}, {63'd0, last_ovf}, {63'd0, exp_ovf});
            checkValue({name, " latency"}, 64'(last_latency), 64'd4);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic c, input logic o, input logic [31:0] exp_sum,
                            input logic exp_cout, input logic exp_ovf);
        int base;
        base = results_seen;
        applyStimulus(a, b, c, o);
        checkOutput(name, base, exp_sum, exp_cout, exp_ovf);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        inputA    = '0;
        inputB    = '0;
        cin       = 1'b0;
        op        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkValue("reset out_valid", {63'd0, out_valid}, 64'd0);
        checkValue("reset addC", {32'd0, addC}, 64'd0);
        checkValue("reset cout", {63'd0, cout}, 64'd0);
        checkValue("reset ovf", {63'd0, ovf}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkValue("in_ready after reset", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        directed("add wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("sub 5-7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub 7-5", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
`ifdef PIPE_ADDER_SAT_EN
        directed("add ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        directed("sub ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
        directed("neg ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
`else
        directed("add ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("sub ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("neg ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
`endif
        directed("add cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
        directed("sub cin ignored", 32'd10, 32'd3, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
        directed("chunk ripple", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0);

        // Eight back-to-back beats with a three-cycle output stall in the middle.
        base = results_seen;
        acc_log.delete();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    applyStimulus(32'hFFFF_FFF0 + 32'(i), 32'(i * 3), 1'(i), 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checkValue("in_ready during stall", {63'd0, in_ready}, 64'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        checkValue("stream result count", 64'(results_seen - base), 64'd8);
        checkValue("stream accept count", 64'(acc_log.size()), 64'd8);
        if (acc_log.size() == 8)
            checkValue("stream accept span", 64'(acc_log[7] - acc_log[0]), 64'd10);

        // Reset with three beats in flight: they must vanish.
        base = results_seen;
        applyStimulus(32'd1, 32'd2, 1'b0, 1'b0);
        applyStimulus(32'd3, 32'd4, 1'b0, 1'b0);
        applyStimulus(32'd5, 32'd6, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkValue("out_valid after mid reset", {63'd0, out_valid}, 64'd0);
        checkValue("in_ready after mid reset", {63'd0, in_ready}, 64'd1);
        repeat (10) @(posedge clk);
        #1;
        checkValue("no stale result", 64'(results_seen - base), 64'd0);

        directed("after reset", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
